// File: rtl/prim_packer_fifo_buf.sv
// Width converter (pack / unpack / pass-through) with a Depth-entry FIFO of the wider word.
// Latency: a write is visible on the read side one cycle later; there is no write-to-read bypass.
// Backpressure: wready_o drops when the FIFO is full; the read head holds while rready_i is low.
module prim_packer_fifo_buf #(
    parameter int InW         = 32,
    parameter int OutW        = 8,
    parameter int Depth       = 2,
    parameter bit ClearOnRead = 1'b1,
    localparam int DW         = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    input  logic [InW-1:0]    wdata_i,
    input  logic              wlast_i,
    output logic              wready_o,
    output logic              rvalid_o,
    output logic [OutW-1:0]   rdata_o,
    output logic [OutW/8-1:0] rmask_o,
    output logic              rlast_o,
    input  logic              rready_i,
    output logic [DW-1:0]     depth_o
);
    localparam int MaxW = (InW > OutW) ? InW : OutW;
    localparam int MinW = (InW > OutW) ? OutW : InW;
    localparam int R    = MaxW / MinW;
    localparam int CW   = (R > 1) ? $clog2(R) : 1;
    localparam int MB   = MaxW / 8;
    localparam int PW   = (Depth > 1) ? $clog2(Depth) : 1;

    logic              r_clr_q;
    logic [MaxW-1:0]   r_mem_dat [Depth];
    logic [MB-1:0]     r_mem_msk [Depth];
    logic [Depth-1:0]  r_mem_lst;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [DW-1:0]     r_depth;

    logic              w_full;
    logic              w_wready;
    logic              w_rvalid;
    logic              w_wr_hs;
    logic              w_rd_hs;
    logic              w_push;
    logic              w_pop;
    logic [MaxW-1:0]   w_push_dat;
    logic [MB-1:0]     w_push_msk;
    logic              w_push_lst;
    logic [MaxW-1:0]   w_head_dat;
    logic [MB-1:0]     w_head_msk;
    logic              w_head_lst;
    logic [OutW-1:0]   w_rdat;
    logic [OutW/8-1:0] w_rmsk;
    logic              w_rlst;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // While the flush is in flight both sides are stalled, so any handshake attempt is dropped.
    assign w_full     = (r_depth == DW'(Depth));
    assign w_wready   = !r_clr_q && !w_full;
    assign w_rvalid   = !r_clr_q && (r_depth != '0);
    assign w_wr_hs    = wvalid_i && w_wready;
    assign w_rd_hs    = w_rvalid && rready_i;
    assign w_head_dat = r_mem_dat[r_rptr];
    assign w_head_msk = r_mem_msk[r_rptr];
    assign w_head_lst = r_mem_lst[r_rptr];

    // Flush request is registered; reset leaves it set so both sides start stalled for a cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_clr_q <= 1'b1;
        else         r_clr_q <= clr_i;
    end

    // FIFO storage, pointers and occupancy; a flush empties it regardless of other activity.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem_dat[i] <= '0;
                r_mem_msk[i] <= '0;
            end
            r_mem_lst <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_depth   <= '0;
        end else if (r_clr_q) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_depth   <= '0;
        end else begin
            if (w_push) begin
                r_mem_dat[r_wptr] <= w_push_dat;
                r_mem_msk[r_wptr] <= w_push_msk;
                r_mem_lst[r_wptr] <= w_push_lst;
                r_wptr            <= ptr_inc(r_wptr);
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);
            if (w_push && !w_pop)      r_depth <= r_depth + 1'b1;
            else if (w_pop && !w_push) r_depth <= r_depth - 1'b1;
        end
    end

    if (InW < OutW) begin : g_pack
        logic [OutW-1:0] r_asm;
        logic [MB-1:0]   r_amsk;
        logic [CW-1:0]   r_cnt;
        logic [OutW-1:0] w_asm;
        logic [MB-1:0]   w_amsk;
        logic            w_close;

        // Drop the incoming narrow word into its slice; a full word or wlast closes it.
        always_comb begin
            w_asm   = r_asm;
            w_amsk  = r_amsk;
            w_asm[r_cnt*InW +: InW]         = wdata_i;
            w_amsk[r_cnt*(InW/8) +: InW/8]  = '1;
            w_close = (r_cnt == CW'(R - 1)) || wlast_i;
        end

        assign w_push     = w_wr_hs && w_close;
        assign w_push_dat = w_asm;
        assign w_push_msk = w_amsk;
        assign w_push_lst = wlast_i;

        // Assembly register restarts empty at slice 0 after every closed word or flush.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_asm  <= '0;
                r_amsk <= '0;
                r_cnt  <= '0;
            end else if (r_clr_q || (w_wr_hs && w_close)) begin
                r_asm  <= '0;
                r_amsk <= '0;
                r_cnt  <= '0;
            end else if (w_wr_hs) begin
                r_asm  <= w_asm;
                r_amsk <= w_amsk;
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end else begin : g_wdirect
        assign w_push     = w_wr_hs;
        assign w_push_dat = wdata_i;
        assign w_push_msk = '1;
        assign w_push_lst = wlast_i;
    end

    if (InW > OutW) begin : g_unpack
        logic [CW-1:0] r_ptr;
        logic          w_at_end;

        assign w_at_end = (r_ptr == CW'(R - 1));
        assign w_rdat   = w_head_dat[r_ptr*OutW +: OutW];
        assign w_rmsk   = w_head_msk[r_ptr*(OutW/8) +: OutW/8];
        assign w_rlst   = w_head_lst && w_at_end;
        assign w_pop    = w_rd_hs && w_at_end;

        // Slice pointer walks the head entry; the last slice read releases the entry.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)      r_ptr <= '0;
            else if (r_clr_q) r_ptr <= '0;
            else if (w_rd_hs) r_ptr <= w_at_end ? '0 : r_ptr + 1'b1;
        end
    end else begin : g_rdirect
        assign w_rdat = w_head_dat;
        assign w_rmsk = w_head_msk;
        assign w_rlst = w_head_lst;
        assign w_pop  = w_rd_hs;
    end

    assign wready_o = w_wready;
    assign rvalid_o = w_rvalid;
    assign rdata_o  = (ClearOnRead && !w_rvalid) ? '0   : w_rdat;
    assign rmask_o  = (ClearOnRead && !w_rvalid) ? '0   : w_rmsk;
    assign rlast_o  = (ClearOnRead && !w_rvalid) ? 1'b0 : w_rlst;
    assign depth_o  = r_depth;
endmodule

// File: tb/tb_prim_packer_fifo_buf.sv
// Bench for prim_packer_fifo_buf: one 8->32 packer and one 32->8 unpacker, both Depth=2.
// A queue-based model tracks what each read side must show; it is compared every cycle.
// Directed vectors add literal expectations for the hand-worked cases.
module tb_prim_packer_fifo_buf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        pk_clr, pk_wvalid, pk_wlast, pk_rready;
    logic [7:0]  pk_wdata;
    logic        pk_wready, pk_rvalid, pk_rlast;
    logic [31:0] pk_rdata;
    logic [3:0]  pk_rmask;
    logic [1:0]  pk_depth;

    logic        up_clr, up_wvalid, up_wlast, up_rready;
    logic [31:0] up_wdata;
    logic        up_wready, up_rvalid, up_rlast;
    logic [7:0]  up_rdata;
    logic [0:0]  up_rmask;
    logic [1:0]  up_depth;

    prim_packer_fifo_buf #(.InW(8), .OutW(32), .Depth(2), .ClearOnRead(1'b1)) u_pk (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(pk_clr),
        .wvalid_i(pk_wvalid), .wdata_i(pk_wdata), .wlast_i(pk_wlast), .wready_o(pk_wready),
        .rvalid_o(pk_rvalid), .rdata_o(pk_rdata), .rmask_o(pk_rmask), .rlast_o(pk_rlast),
        .rready_i(pk_rready), .depth_o(pk_depth)
    );

    prim_packer_fifo_buf #(.InW(32), .OutW(8), .Depth(2), .ClearOnRead(1'b1)) u_up (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(up_clr),
        .wvalid_i(up_wvalid), .wdata_i(up_wdata), .wlast_i(up_wlast), .wready_o(up_wready),
        .rvalid_o(up_rvalid), .rdata_o(up_rdata), .rmask_o(up_rmask), .rlast_o(up_rlast),
        .rready_i(up_rready), .depth_o(up_depth)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        lst;
        logic [3:0]  msk;
        logic [31:0] dat;
    } pk_ent_t;

    pk_ent_t     pk_q[$];
    logic [31:0] pk_acc;
    logic [3:0]  pk_accm;
    int          pk_n;
    bit          pk_clrq;
    logic [8:0]  up_q[$];   // one element per output byte: {last, byte}
    bit          up_clrq;

    function automatic int up_entries();
        return (up_q.size() + 3) / 4;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            pk_q.delete(); pk_acc = '0; pk_accm = '0; pk_n = 0; pk_clrq = 1'b1;
            up_q.delete(); up_clrq = 1'b1;
        end else begin
            bit pw, pr, uw, ur;
            pk_ent_t e;
            pw = pk_wvalid && !pk_clrq && (pk_q.size() < 2);
            pr = pk_rready && !pk_clrq && (pk_q.size() > 0);
            uw = up_wvalid && !up_clrq && (up_entries() < 2);
            ur = up_rready && !up_clrq && (up_q.size() > 0);
            if (pk_clrq) begin
                pk_q.delete(); pk_acc = '0; pk_accm = '0; pk_n = 0;
            end else begin
                if (pr) void'(pk_q.pop_front());
                if (pw) begin
                    pk_acc = pk_acc | (32'(pk_wdata) << (8 * pk_n));
                    pk_accm[pk_n] = 1'b1;
                    pk_n++;
                    if (pk_n == 4 || pk_wlast) begin
                        e.lst = pk_wlast; e.msk = pk_accm; e.dat = pk_acc;
                        pk_q.push_back(e);
                        pk_acc = '0; pk_accm = '0; pk_n = 0;
                    end
                end
            end
            pk_clrq = pk_clr;
            if (up_clrq) begin
                up_q.delete();
            end else begin
                if (ur) void'(up_q.pop_front());
                if (uw) for (int i = 0; i < 4; i++)
                    up_q.push_back({up_wlast && (i == 3), up_wdata[8*i +: 8]});
            end
            up_clrq = up_clr;
        end
    end

    // ---------------- every-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        chk("pk_wready", 32'(pk_wready), 32'(!pk_clrq && pk_q.size() < 2));
        chk("pk_rvalid", 32'(pk_rvalid), 32'(!pk_clrq && pk_q.size() > 0));
        chk("pk_depth",  32'(pk_depth),  32'(pk_q.size()));
        if (!pk_clrq && pk_q.size() > 0) begin
            chk("pk_rdata", pk_rdata,        pk_q[0].dat);
            chk("pk_rmask", 32'(pk_rmask),   32'(pk_q[0].msk));
            chk("pk_rlast", 32'(pk_rlast),   32'(pk_q[0].lst));
        end else begin
            chk("pk_idle_out", {pk_rdata[27:0], pk_rmask, 32'(0)} == '0 ? 32'(pk_rlast) : 32'hBAD, 32'h0);
        end
        chk("up_wready", 32'(up_wready), 32'(!up_clrq && up_entries() < 2));
        chk("up_rvalid", 32'(up_rvalid), 32'(!up_clrq && up_q.size() > 0));
        chk("up_depth",  32'(up_depth),  32'(up_entries()));
        if (!up_clrq && up_q.size() > 0) begin
            chk("up_rdata", 32'(up_rdata), 32'(up_q[0][7:0]));
            chk("up_rmask", 32'(up_rmask), 32'h1);
            chk("up_rlast", 32'(up_rlast), 32'(up_q[0][8]));
        end else begin
            chk("up_idle_out", {23'(0), up_rlast, up_rdata} | 32'(up_rmask), 32'h0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic pk_wr(input logic [7:0] d, input logic l);
        @(negedge clk);
        pk_wvalid = 1'b1; pk_wdata = d; pk_wlast = l; pk_rready = 1'b0;
    endtask

    task automatic pk_idle();
        @(negedge clk);
        pk_wvalid = 1'b0; pk_wlast = 1'b0; pk_rready = 1'b0;
    endtask

    logic [7:0] ub [4];
    logic [7:0] pat;
    int         idx;

    initial begin
        pk_clr = 0; pk_wvalid = 0; pk_wlast = 0; pk_rready = 0; pk_wdata = '0;
        up_clr = 0; up_wvalid = 0; up_wlast = 0; up_rready = 0; up_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_pk_wready_hold", 32'(pk_wready), 32'h0);
        chk("rst_up_rvalid",      32'(up_rvalid), 32'h0);
        chk("rst_pk_depth",       32'(pk_depth),  32'h0);
        @(negedge clk);
        chk("post_rst_pk_wready", 32'(pk_wready), 32'h1);
        chk("post_rst_up_wready", 32'(up_wready), 32'h1);

        // Full 4-byte pack
        pk_wr(8'h11, 0); pk_wr(8'h22, 0); pk_wr(8'h33, 0); pk_wr(8'h44, 0);
        pk_idle();
        chk("t1_rdata",  pk_rdata,         32'h44332211);
        chk("t1_rmask",  32'(pk_rmask),    32'hF);
        chk("t1_rlast",  32'(pk_rlast),    32'h0);
        chk("t1_depth",  32'(pk_depth),    32'h1);
        pk_rready = 1'b1;
        pk_idle();
        chk("t1_drained", 32'(pk_depth), 32'h0);

        // Fill both entries, try a write while full, then release one entry
        for (int i = 1; i <= 8; i++) pk_wr(8'(i), 0);
        pk_idle();
        chk("t3_depth_full", 32'(pk_depth),  32'h2);
        chk("t3_wready_low", 32'(pk_wready), 32'h0);
        chk("t3_head",       pk_rdata,       32'h04030201);
        pk_wr(8'h99, 0);
        pk_idle();
        chk("t3_full_write_dropped", 32'(pk_depth), 32'h2);
        pk_rready = 1'b1;
        @(negedge clk);
        chk("t3_wready_back", 32'(pk_wready), 32'h1);
        chk("t3_depth_one",   32'(pk_depth),  32'h1);
        chk("t3_second",      pk_rdata,       32'h08070605);
        @(negedge clk);
        pk_rready = 1'b0;
        chk("t3_drained", 32'(pk_depth), 32'h0);

        // Partial word closed by wlast
        pk_wr(8'h11, 0); pk_wr(8'h22, 1);
        pk_idle();
        chk("t2_rdata", pk_rdata,      32'h00002211);
        chk("t2_rmask", 32'(pk_rmask), 32'h3);
        chk("t2_rlast", 32'(pk_rlast), 32'h1);
        pk_rready = 1'b1;
        pk_idle();

        // Flush with one entry queued and three slices assembled
        pk_wr(8'h01, 0); pk_wr(8'h02, 0); pk_wr(8'h03, 0); pk_wr(8'h04, 0);
        pk_wr(8'hAA, 0); pk_wr(8'hBB, 0); pk_wr(8'hCC, 0);
        pk_idle();
        chk("t5_queued", 32'(pk_depth), 32'h1);
        pk_clr = 1'b1;
        @(negedge clk);
        pk_clr = 1'b0;
        chk("t5_clr_rvalid", 32'(pk_rvalid), 32'h0);
        chk("t5_clr_wready", 32'(pk_wready), 32'h0);
        @(negedge clk);
        chk("t5_depth_zero", 32'(pk_depth),  32'h0);
        chk("t5_wready_on",  32'(pk_wready), 32'h1);
        pk_wr(8'h05, 0); pk_wr(8'h06, 0); pk_wr(8'h07, 0); pk_wr(8'h08, 0);
        pk_idle();
        chk("t5_fresh_word", pk_rdata,      32'h08070605);
        chk("t5_fresh_mask", 32'(pk_rmask), 32'hF);
        pk_rready = 1'b1;
        pk_idle();

        // Unpack with a stalling reader
        ub[0] = 8'hD4; ub[1] = 8'hC3; ub[2] = 8'hB2; ub[3] = 8'hA1;
        pat = 8'b1011_0010;
        @(negedge clk);
        up_wvalid = 1'b1; up_wdata = 32'hA1B2C3D4; up_wlast = 1'b1;
        @(negedge clk);
        up_wvalid = 1'b0; up_wlast = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            chk("t4_rdata", 32'(up_rdata),  32'(ub[idx]));
            chk("t4_rlast", 32'(up_rlast),  32'(idx == 3));
            chk("t4_depth", 32'(up_depth),  32'h1);
            up_rready = pat[c];
            if (pat[c]) idx++;
            @(negedge clk);
        end
        up_rready = 1'b0;
        chk("t4_depth_zero", 32'(up_depth),  32'h0);
        chk("t4_rvalid_off", 32'(up_rvalid), 32'h0);

        // Reset in the middle of an unpack
        up_wvalid = 1'b1; up_wdata = 32'h44332211; up_wlast = 1'b1;
        @(negedge clk);
        up_wvalid = 1'b0; up_wlast = 1'b0; up_rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        up_rready = 1'b0;
        chk("t6_ptr2_data", 32'(up_rdata), 32'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_rvalid", 32'(up_rvalid), 32'h0);
        chk("t6_rst_rdata",  32'(up_rdata),  32'h0);
        chk("t6_rst_depth",  32'(up_depth),  32'h0);
        chk("t6_rst_wready", 32'(up_wready), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("t6_release_hold", 32'(up_wready), 32'h0);
        @(negedge clk);
        chk("t6_wready_back", 32'(up_wready), 32'h1);
        up_wvalid = 1'b1; up_wdata = 32'h0D0C0B0A; up_wlast = 1'b1;
        @(negedge clk);
        up_wvalid = 1'b0; up_wlast = 1'b0;
        chk("t6_resume_first", 32'(up_rdata), 32'h0A);
        up_rready = 1'b1;
        repeat (4) @(negedge clk);
        up_rready = 1'b0;
        chk("t6_resume_drained", 32'(up_depth), 32'h0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
